// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: FSM state codes, default timing
// parameters and a counter-width helper used by the gate blocks.
package parking_pkg;

  localparam int DEBOUNCE_DEF     = 4;
  localparam int BADGE_WINDOW_DEF = 16;
  localparam int PASS_TIMEOUT_DEF = 200;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLASSIFY   = 3'd1;
  localparam logic [2:0] S_CHECK      = 3'd2;
  localparam logic [2:0] S_OPEN       = 3'd3;
  localparam logic [2:0] S_WAIT_CLEAR = 3'd4;
  localparam logic [2:0] S_DENY       = 3'd5;

  // Width of a counter that must reach n-1; never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/loop_debounce.sv
// Loop-detector debouncer: level follows raw after DEBOUNCE consecutive
// disagreeing samples. Ports: clk, rst (sync, high), raw in, level out.
module loop_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_w(DEBOUNCE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Any agreeing sample restarts the run of disagreeing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (raw != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/entry_gate_ctrl.sv
// Entry barrier controller: debounces arrive/pass loops, classifies the car,
// checks vacancy, drives barrier/deny and emits one car_entered per car.
// Inputs: clk, rst, enabled, loop_arrive, loop_pass, badge_valid,
// uni_is_vacated_space, is_vacated_space. Outputs (all registered):
// barrier_open, deny, car_entered, is_uni_car_entered, timeout.
module entry_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int BADGE_WINDOW = BADGE_WINDOW_DEF,
  parameter int PASS_TIMEOUT = PASS_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enabled,
  input  logic loop_arrive,
  input  logic loop_pass,
  input  logic badge_valid,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic barrier_open,
  output logic deny,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic timeout
);

  localparam int BCW = cnt_w(BADGE_WINDOW);
  localparam int TCW = cnt_w(PASS_TIMEOUT);

  logic           arr_lvl, pass_lvl;
  logic           arr_prev_q, pass_prev_q;
  logic           arr_rise, pass_rise;
  logic           vac;

  logic [2:0]     state_q, state_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [TCW-1:0] tmr_q, tmr_d;
  logic           uni_q, uni_d;

  logic           bo_q, bo_d;
  logic           deny_q, deny_d;
  logic           ce_q, ce_d;
  logic           uce_q, uce_d;
  logic           to_q, to_d;

  loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_arr_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (loop_arrive),
    .level (arr_lvl)
  );

  loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_pass_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (loop_pass),
    .level (pass_lvl)
  );

  assign arr_rise  = arr_lvl & ~arr_prev_q;
  assign pass_rise = pass_lvl & ~pass_prev_q;
  assign vac       = uni_q ? uni_is_vacated_space : is_vacated_space;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      tmr_q       <= '0;
      uni_q       <= 1'b0;
      arr_prev_q  <= 1'b0;
      pass_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tmr_q       <= tmr_d;
      uni_q       <= uni_d;
      arr_prev_q  <= arr_lvl;
      pass_prev_q <= pass_lvl;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    tmr_d   = tmr_q;
    uni_d   = uni_q;
    case (state_q)
      S_IDLE: begin
        if (arr_rise) begin
          state_d = S_CLASSIFY;
          bcnt_d  = '0;
          uni_d   = 1'b0;
        end
      end
      S_CLASSIFY: begin
        if (!arr_lvl) begin
          state_d = S_IDLE;
        end else if (badge_valid) begin
          uni_d   = 1'b1;
          state_d = S_CHECK;
        end else if (bcnt_q == BCW'(BADGE_WINDOW - 1)) begin
          state_d = S_CHECK;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (vac) begin
          state_d = S_OPEN;
          tmr_d   = '0;
        end else begin
          state_d = S_DENY;
        end
      end
      S_OPEN: begin
        if (pass_rise) begin
          state_d = S_WAIT_CLEAR;
        end else if (tmr_q == TCW'(PASS_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WAIT_CLEAR: begin
        if (!pass_lvl) state_d = S_IDLE;
      end
      S_DENY: begin
        if (!arr_lvl) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enabled) state_d = S_IDLE;
  end

  // Outputs are decoded from the transition being taken so that the
  // registered value lines up with the new state.
  always_comb begin
    bo_d   = 1'b0;
    deny_d = 1'b0;
    ce_d   = 1'b0;
    uce_d  = 1'b0;
    to_d   = 1'b0;
    if (enabled) begin
      bo_d   = (state_d == S_OPEN) || (state_d == S_WAIT_CLEAR);
      deny_d = (state_d == S_DENY);
      ce_d   = (state_q == S_OPEN) && (state_d == S_WAIT_CLEAR);
      uce_d  = ce_d & uni_q;
      to_d   = (state_q == S_OPEN) && (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bo_q   <= 1'b0;
      deny_q <= 1'b0;
      ce_q   <= 1'b0;
      uce_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      bo_q   <= bo_d;
      deny_q <= deny_d;
      ce_q   <= ce_d;
      uce_q  <= uce_d;
      to_q   <= to_d;
    end
  end

  assign barrier_open       = bo_q;
  assign deny               = deny_q;
  assign car_entered        = ce_q;
  assign is_uni_car_entered = uce_q;
  assign timeout            = to_q;

endmodule

// File: tb/tb_entry_gate_ctrl.sv
// Self-checking bench for entry_gate_ctrl: directed scenarios plus random
// car transactions checked against a timing/classification model.
module tb_entry_gate_ctrl;

  localparam int DB = 4;
  localparam int BW = 16;
  localparam int PT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enabled = 1'b1;
  logic loop_arrive = 1'b0;
  logic loop_pass = 1'b0;
  logic badge_valid = 1'b0;
  logic uni_vac = 1'b0;
  logic gen_vac = 1'b0;
  logic barrier_open, deny, car_entered, is_uni_car_entered, timeout;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  int to_cnt = 0;
  int mon_bad = 0;
  logic prev_ce = 1'b0;
  logic prev_to = 1'b0;

  always #5 clk = ~clk;

  entry_gate_ctrl #(
    .DEBOUNCE     (DB),
    .BADGE_WINDOW (BW),
    .PASS_TIMEOUT (PT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enabled              (enabled),
    .loop_arrive          (loop_arrive),
    .loop_pass            (loop_pass),
    .badge_valid          (badge_valid),
    .uni_is_vacated_space (uni_vac),
    .is_vacated_space     (gen_vac),
    .barrier_open         (barrier_open),
    .deny                 (deny),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .timeout              (timeout)
  );

  // Pulse counters and pulse-shape invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (car_entered) ce_cnt++;
    if (timeout) to_cnt++;
    if (!car_entered && is_uni_car_entered) mon_bad++;
    if (car_entered && prev_ce) mon_bad++;
    if (timeout && prev_to) mon_bad++;
    prev_ce = car_entered;
    prev_to = timeout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int outs();
    return {barrier_open, deny, car_entered, is_uni_car_entered, timeout};
  endfunction

  // One car. bc = CLASSIFY cycle (0-based) of the badge strobe, -1 = none.
  task automatic car(input int bc, input bit uv, input bit gv,
                     input int wait_open, input int hold_deny);
    bit uni, vac;
    int tdec, ce0;
    uni  = (bc >= 0) && (bc < BW);
    vac  = uni ? uv : gv;
    tdec = uni ? bc + 2 : BW + 1;
    ce0  = ce_cnt;
    uni_vac = uv;
    gen_vac = gv;
    loop_arrive = 1'b1;
    tick(DB + 1);
    chk("arrive_quiet", outs(), 0);
    for (int t = 1; t <= tdec; t++) begin
      badge_valid = (t - 1 == bc);
      tick();
      badge_valid = 1'b0;
      if (t == tdec - 1) chk("pre_decision", {barrier_open, deny}, 0);
    end
    chk("decision", {barrier_open, deny}, vac ? 2 : 1);
    uni_vac = ~uv;
    gen_vac = ~gv;
    if (vac) begin
      tick(wait_open);
      chk("open_hold", barrier_open, 1);
      loop_arrive = 1'b0;
      loop_pass = 1'b1;
      tick(DB);
      chk("ce_early", car_entered, 0);
      tick();
      chk("ce_pulse", car_entered, 1);
      chk("ce_class", is_uni_car_entered, uni);
      tick();
      chk("ce_width", car_entered, 0);
      loop_pass = 1'b0;
      tick(2);
      loop_pass = 1'b1;
      tick(DB + 2);
      chk("wait_clear_open", barrier_open, 1);
      loop_pass = 1'b0;
      tick(DB);
      chk("bar_before_clear", barrier_open, 1);
      tick();
      chk("bar_closed", barrier_open, 0);
      loop_pass = 1'b1;
      tick(DB + 3);
      loop_pass = 1'b0;
      tick(DB + 2);
      chk("one_car", ce_cnt - ce0, 1);
    end else begin
      tick(hold_deny);
      chk("deny_hold", deny, 1);
      loop_arrive = 1'b0;
      tick(DB);
      chk("deny_until_clear", deny, 1);
      tick();
      chk("deny_off", deny, 0);
      chk("no_car", ce_cnt - ce0, 0);
    end
    tick(2);
  endtask

  initial begin
    int ce0, bc;
    tick(2);
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    tick();
    chk("post_reset_outs", outs(), 0);

    // General car with vacancy, then university car with uni section full.
    car(-1, 1'b0, 1'b1, 3, 0);
    car(3, 1'b0, 1'b1, 0, 4);
    // Badge on the last window cycle counts; one cycle later it does not.
    car(15, 1'b1, 1'b0, 2, 0);
    car(16, 1'b0, 1'b1, 5, 0);

    // Glitches: short pulses and an interrupted run never toggle a loop.
    ce0 = ce_cnt;
    uni_vac = 1'b1;
    gen_vac = 1'b1;
    loop_arrive = 1'b1;
    tick(DB - 1);
    loop_arrive = 1'b0;
    tick();
    loop_arrive = 1'b1;
    tick(DB - 1);
    loop_arrive = 1'b0;
    tick(BW + DB + 5);
    chk("glitch_arrive", outs(), 0);
    loop_pass = 1'b1;
    tick(DB - 1);
    loop_pass = 1'b0;
    tick(10);
    chk("glitch_pass", outs(), 0);
    chk("glitch_no_car", ce_cnt - ce0, 0);

    // Timeout: barrier open for PT cycles, then closes with a pulse.
    ce0 = ce_cnt;
    loop_arrive = 1'b1;
    tick(DB + 1 + BW + 1);
    chk("to_open", barrier_open, 1);
    tick(PT - 1);
    chk("to_last_open", {barrier_open, timeout}, 2);
    tick();
    chk("to_pulse", {barrier_open, timeout}, 1);
    tick();
    chk("to_width", timeout, 0);
    chk("to_count", to_cnt, 1);
    chk("to_no_car", ce_cnt - ce0, 0);
    loop_arrive = 1'b0;
    tick(DB + 2);

    // enabled drops on the edge that would emit car_entered.
    ce0 = ce_cnt;
    loop_arrive = 1'b1;
    tick(DB + 1 + BW + 1);
    chk("dis_open", barrier_open, 1);
    tick(3);
    loop_arrive = 1'b0;
    loop_pass = 1'b1;
    tick(DB);
    enabled = 1'b0;
    tick();
    chk("dis_outs", outs(), 0);
    enabled = 1'b1;
    tick(DB + 3);
    chk("dis_idle", outs(), 0);
    loop_pass = 1'b0;
    tick(DB + 2);
    chk("dis_no_car", ce_cnt - ce0, 0);

    // rst during WAIT_CLEAR closes the barrier at once.
    ce0 = ce_cnt;
    loop_arrive = 1'b1;
    tick(DB + 1 + BW + 1);
    loop_arrive = 1'b0;
    loop_pass = 1'b1;
    tick(DB + 1);
    chk("rst_ce", car_entered, 1);
    tick(2);
    chk("rst_wait_clear", barrier_open, 1);
    rst = 1'b1;
    tick();
    chk("rst_outs", outs(), 0);
    rst = 1'b0;
    tick(DB + 3);
    chk("rst_idle", outs(), 0);
    loop_pass = 1'b0;
    tick(DB + 2);
    chk("rst_one_car", ce_cnt - ce0, 1);

    // Random transactions.
    for (int i = 0; i < 12; i++) begin
      bc = $urandom_range(0, 22);
      if (bc > 19) bc = -1;
      car(bc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 40), $urandom_range(0, 6));
    end

    chk("pulse_invariants", mon_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
